instr_issuer: RTL and testbench

//  Drives the single-cycle datapath (control + register file + ALU) from a loadable program.

---
 rtl/issuer_pkg.sv | 33 +++
 rtl/issue_mem.sv | 26 ++
 rtl/instr_issuer.sv | 166 ++++++++++++++++
 tb/tb_instr_issuer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/issuer_pkg.sv
// Shared types and constants for the instruction issuer: sequencer states,
// instruction field positions and default opcode/NOP encodings.
package issuer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int INSTR_W   = 16;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int WADDR_MSB = 11;
  localparam int WADDR_LSB = 8;
  localparam int INIT_AW   = 4;

  localparam logic [3:0]         DEF_INIT_OP   = 4'h0;
  localparam logic [3:0]         DEF_HALT_OP   = 4'hF;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'hF000;

  // Register-write word used in INIT: operand fields are don't-care for the datapath.
  function automatic logic [INSTR_W-1:0] init_word(input logic [3:0] op,
                                                   input logic [3:0] waddr);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]       = op;
    w[WADDR_MSB:WADDR_LSB] = waddr;
    return w;
  endfunction

endpackage

// File: rtl/issue_mem.sv
// Small word memory with synchronous write and asynchronous read; used for both
// the program store and the register init table.
module issue_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Sequencer that initialises the datapath register file from a table and then
// streams program words into it one per cycle until HALT or end of memory.
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int                 PC_W      = 6,
  parameter int                 NUM_INIT  = 16,
  parameter logic [3:0]         INIT_OP   = DEF_INIT_OP,
  parameter logic [3:0]         HALT_OP   = DEF_HALT_OP,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                load_en,
  input  logic                load_tgt,
  input  logic [PC_W-1:0]     load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  output logic [INSTR_W-1:0]  instruction,
  output logic [INSTR_W-1:0]  data_init,
  output logic                init_sel,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                done
);

  localparam int                DEPTH     = 2 ** PC_W;
  localparam int                CNT_W     = 5;
  localparam logic [CNT_W-1:0]  LAST_INIT = CNT_W'(NUM_INIT - 1);
  localparam logic [PC_W-1:0]   LAST_PC   = {PC_W{1'b1}};

  state_t               state_reg, state_next;
  logic [PC_W-1:0]      pc_reg, pc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [INSTR_W-1:0]   instr_reg, instr_next;
  logic [INSTR_W-1:0]   data_init_reg, data_init_next;
  logic                 init_sel_reg, init_sel_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  logic                 mem_wr;
  logic                 prog_we;
  logic                 init_we;
  logic [INIT_AW-1:0]   init_waddr;
  logic [INSTR_W-1:0]   prog_rdata;
  logic [INSTR_W-1:0]   init_rdata;

  // Memories are only writable while the sequencer is not reading them.
  assign mem_wr  = load_en && ((state_reg == IDLE) || (state_reg == DONE));
  assign prog_we = mem_wr && !load_tgt;
  assign init_we = mem_wr && load_tgt;

  // Init table address is the low nibble of load_addr, zero-extended for narrow PC_W.
  for (genvar gi = 0; gi < INIT_AW; gi++) begin : g_init_waddr
    if (gi < PC_W) begin : g_bit
      assign init_waddr[gi] = load_addr[gi];
    end else begin : g_zero
      assign init_waddr[gi] = 1'b0;
    end
  end

  issue_mem #(
    .DEPTH (DEPTH),
    .AW    (PC_W),
    .DW    (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (prog_rdata)
  );

  issue_mem #(
    .DEPTH (2 ** INIT_AW),
    .AW    (INIT_AW),
    .DW    (INSTR_W)
  ) u_init_mem (
    .clk   (clk),
    .we    (init_we),
    .waddr (init_waddr),
    .wdata (load_data),
    .raddr (cnt_reg[INIT_AW-1:0]),
    .rdata (init_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    cnt_next       = cnt_reg;
    instr_next     = NOP_INSTR;
    data_init_next = data_init_reg;
    init_sel_next  = 1'b1;

    if (!stall) begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_next = INIT;
            cnt_next   = '0;
          end
        end
        INIT: begin
          instr_next     = init_word(INIT_OP, cnt_reg[INIT_AW-1:0]);
          data_init_next = init_rdata;
          init_sel_next  = 1'b0;
          if (cnt_reg == LAST_INIT) begin
            state_next = RUN;
            pc_next    = '0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          // HALT is consumed here and never reaches the datapath.
          if (prog_rdata[OP_MSB:OP_LSB] == HALT_OP) begin
            state_next = DONE;
          end else begin
            instr_next = prog_rdata;
            pc_next    = pc_reg + PC_W'(1);
            if (pc_reg == LAST_PC) begin
              state_next = DONE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next == INIT) || (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      cnt_reg       <= '0;
      instr_reg     <= NOP_INSTR;
      data_init_reg <= '0;
      init_sel_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      cnt_reg       <= cnt_next;
      instr_reg     <= instr_next;
      data_init_reg <= data_init_next;
      init_sel_reg  <= init_sel_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign instruction = instr_reg;
  assign data_init   = data_init_reg;
  assign init_sel    = init_sel_reg;
  assign pc          = pc_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a PC_W=6 instance for the main scenarios and a
// PC_W=2 instance for end-of-memory wraparound.
module tb_instr_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stall, load_en, load_tgt;
  logic [5:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] instruction, data_init;
  logic        init_sel, busy, done;
  logic [5:0]  pc;

  logic        b_start, b_stall, b_load_en, b_load_tgt;
  logic [1:0]  b_load_addr;
  logic [15:0] b_load_data;
  logic [15:0] b_instruction, b_data_init;
  logic        b_init_sel, b_busy, b_done;
  logic [1:0]  b_pc;

  int checks = 0;
  int errors = 0;

  instr_issuer #(.PC_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .load_en(load_en), .load_tgt(load_tgt), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .data_init(data_init), .init_sel(init_sel),
    .pc(pc), .busy(busy), .done(done)
  );

  instr_issuer #(.PC_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(b_start), .stall(b_stall),
    .load_en(b_load_en), .load_tgt(b_load_tgt), .load_addr(b_load_addr), .load_data(b_load_data),
    .instruction(b_instruction), .data_init(b_data_init), .init_sel(b_init_sel),
    .pc(b_pc), .busy(b_busy), .done(b_done)
  );

  logic [15:0] prog_words [4];
  logic [15:0] wrap_words [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (instruction !== 16'hF000) begin errors++; $display("FAIL reset_instr: got %h want f000", instruction); end
    checks++; if (init_sel !== 1'b1) begin errors++; $display("FAIL reset_init_sel: got %b want 1", init_sel); end
    checks++; if (data_init !== 16'h0000) begin errors++; $display("FAIL reset_data_init: got %h want 0000", data_init); end
    checks++; if (pc !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (b_instruction !== 16'hF000 || b_pc !== 2'd0) begin errors++; $display("FAIL reset_dut2: got %h/%0d want f000/0", b_instruction, b_pc); end
    reset = 1'b0;
    $display("reset: instr=%h init_sel=%b pc=%0d", instruction, init_sel, pc);
  endtask

  task automatic test_load();
    for (int k = 0; k < 16; k++) begin
      load_en = 1'b1; load_tgt = 1'b1; load_addr = 6'(k); load_data = 16'(k * 16'h0100);
      step();
      $display("load init[%0d]=%h", k, load_data);
    end
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_tgt = 1'b0; load_addr = 6'(i); load_data = prog_words[i];
      b_load_en = 1'b1; b_load_tgt = 1'b0; b_load_addr = 2'(i); b_load_data = wrap_words[i];
      step();
      $display("load prog[%0d]=%h prog2[%0d]=%h", i, load_data, i, b_load_data);
    end
    load_en = 1'b0;
    b_load_en = 1'b0;
  endtask

  // INIT phase; a program write to address 1 is attempted throughout and must be dropped.
  task automatic test_init();
    logic [15:0] exp_instr;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || instruction !== 16'hF000) begin errors++; $display("FAIL init_start: got busy=%b instr=%h want 1/f000", busy, instruction); end
    load_en = 1'b1; load_tgt = 1'b0; load_addr = 6'd1; load_data = 16'hBEEF;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_instr = {4'h0, 4'(k), 8'h00};
      $display("init k=%0d instr=%h data=%h sel=%b", k, instruction, data_init, init_sel);
      checks++; if (instruction !== exp_instr) begin errors++; $display("FAIL init_instr[%0d]: got %h want %h", k, instruction, exp_instr); end
      checks++; if (data_init !== 16'(k * 16'h0100)) begin errors++; $display("FAIL init_data[%0d]: got %h want %h", k, data_init, 16'(k * 16'h0100)); end
      checks++; if (init_sel !== 1'b0) begin errors++; $display("FAIL init_sel[%0d]: got %b want 0", k, init_sel); end
    end
    load_en = 1'b0;
    checks++; if (pc !== 6'd0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL init_to_run: got pc=%0d busy=%b done=%b want 0/1/0", pc, busy, done); end
  endtask

  task automatic test_run_halt();
    for (int i = 0; i < 3; i++) begin
      step();
      $display("run pc=%0d instr=%h", pc, instruction);
      checks++; if (instruction !== prog_words[i]) begin errors++; $display("FAIL run_instr[%0d]: got %h want %h", i, instruction, prog_words[i]); end
      checks++; if (init_sel !== 1'b1 || pc !== 6'(i + 1)) begin errors++; $display("FAIL run_pc[%0d]: got sel=%b pc=%0d want 1/%0d", i, init_sel, pc, i + 1); end
    end
    step();
    checks++; if (instruction !== 16'hF000) begin errors++; $display("FAIL halt_nop: got %h want f000", instruction); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pc !== 6'd3) begin errors++; $display("FAIL halt_state: got done=%b busy=%b pc=%0d want 1/0/3", done, busy, pc); end
    step();
    checks++; if (done !== 1'b1 || instruction !== 16'hF000 || pc !== 6'd3) begin errors++; $display("FAIL done_hold: got done=%b instr=%h pc=%0d want 1/f000/3", done, instruction, pc); end
    $display("halt: done=%b pc=%0d", done, pc);
  endtask

  task automatic test_stall();
    stall = 1'b1; start = 1'b1;
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_beats_start: got done=%b busy=%b want 1/0", done, busy); end
    stall = 1'b0;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rerun_start: got busy=%b done=%b want 1/0", busy, done); end
    for (int k = 0; k < 16; k++) step();
    checks++; if (data_init !== 16'h0F00) begin errors++; $display("FAIL rerun_last_init: got %h want 0f00", data_init); end
    step();
    checks++; if (instruction !== 16'h1123 || pc !== 6'd1) begin errors++; $display("FAIL stall_pre: got %h pc=%0d want 1123/1", instruction, pc); end
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      $display("stall s=%0d instr=%h pc=%0d", s, instruction, pc);
      checks++; if (instruction !== 16'hF000 || init_sel !== 1'b1) begin errors++; $display("FAIL stall_nop[%0d]: got %h sel=%b want f000/1", s, instruction, init_sel); end
      checks++; if (pc !== 6'd1 || busy !== 1'b1) begin errors++; $display("FAIL stall_pc[%0d]: got pc=%0d busy=%b want 1/1", s, pc, busy); end
    end
    checks++; if (data_init !== 16'h0F00) begin errors++; $display("FAIL stall_data_hold: got %h want 0f00", data_init); end
    stall = 1'b0;
    step();
    checks++; if (instruction !== 16'h2231 || pc !== 6'd2) begin errors++; $display("FAIL stall_resume: got %h pc=%0d want 2231/2", instruction, pc); end
    step();
    checks++; if (instruction !== 16'h3312 || pc !== 6'd3) begin errors++; $display("FAIL stall_next: got %h pc=%0d want 3312/3", instruction, pc); end
    step();
    checks++; if (instruction !== 16'hF000 || done !== 1'b1) begin errors++; $display("FAIL stall_halt: got %h done=%b want f000/1", instruction, done); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) step();
    step();
    step();
    checks++; if (instruction !== 16'h2231 || pc !== 6'd2) begin errors++; $display("FAIL midrun_pre: got %h pc=%0d want 2231/2", instruction, pc); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("midrun reset: instr=%h pc=%0d busy=%b", instruction, pc, busy);
    checks++; if (instruction !== 16'hF000 || pc !== 6'd0 || init_sel !== 1'b1) begin errors++; $display("FAIL midrun_reset: got %h pc=%0d sel=%b want f000/0/1", instruction, pc, init_sel); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || data_init !== 16'h0000) begin errors++; $display("FAIL midrun_state: got busy=%b done=%b data=%h want 0/0/0000", busy, done, data_init); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_idle: got busy=%b want 0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++; if (instruction !== {4'h0, 4'(k), 8'h00} || init_sel !== 1'b0) begin errors++; $display("FAIL midrun_init[%0d]: got %h sel=%b", k, instruction, init_sel); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instruction !== prog_words[i]) begin errors++; $display("FAIL midrun_run[%0d]: got %h want %h", i, instruction, prog_words[i]); end
    end
    step();
    checks++; if (done !== 1'b1 || pc !== 6'd3) begin errors++; $display("FAIL midrun_done: got done=%b pc=%0d want 1/3", done, pc); end
  endtask

  task automatic test_wrap();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 16; k++) step();
    for (int i = 0; i < 4; i++) begin
      step();
      $display("wrap pc=%0d instr=%h done=%b", b_pc, b_instruction, b_done);
      checks++; if (b_instruction !== wrap_words[i] || b_pc !== 2'(i + 1)) begin errors++; $display("FAIL wrap_issue[%0d]: got %h pc=%0d want %h/%0d", i, b_instruction, b_pc, wrap_words[i], 2'(i + 1)); end
    end
    checks++; if (b_done !== 1'b1 || b_busy !== 1'b0 || b_pc !== 2'd0) begin errors++; $display("FAIL wrap_done: got done=%b busy=%b pc=%0d want 1/0/0", b_done, b_busy, b_pc); end
    step();
    checks++; if (b_instruction !== 16'hF000 || b_done !== 1'b1) begin errors++; $display("FAIL wrap_hold: got %h done=%b want f000/1", b_instruction, b_done); end
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    checks++; if (b_busy !== 1'b1 || b_done !== 1'b0) begin errors++; $display("FAIL wrap_rerun: got busy=%b done=%b want 1/0", b_busy, b_done); end
    step();
    checks++; if (b_instruction !== 16'h0000 || b_init_sel !== 1'b0) begin errors++; $display("FAIL wrap_reinit: got %h sel=%b want 0000/0", b_instruction, b_init_sel); end
  endtask

  initial begin
    prog_words[0] = 16'h1123; prog_words[1] = 16'h2231;
    prog_words[2] = 16'h3312; prog_words[3] = 16'hF000;
    wrap_words[0] = 16'h1001; wrap_words[1] = 16'h2002;
    wrap_words[2] = 16'h3003; wrap_words[3] = 16'h4004;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    load_en = 1'b0; load_tgt = 1'b0; load_addr = '0; load_data = '0;
    b_start = 1'b0; b_stall = 1'b0;
    b_load_en = 1'b0; b_load_tgt = 1'b0; b_load_addr = '0; b_load_data = '0;

    test_reset();
    test_load();
    test_init();
    test_run_halt();
    test_stall();
    test_reset_mid_run();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
